parallel_to_serial: RTL and testbench

Converts a `width`-bit parallel word, accepted through a valid/ready handshake, into a stream of single bits on a serial valid/ready interface. It is the transmit-side counterpart of `serial_to_parallel`: one word in, `width` bits out, LSB first by default. Back-to-back words stream with no idle cycle, and downstream back-pressure stalls the shifter bit by bit.

---
 rtl/parallel_to_serial.sv | 89 ++++++++
 tb/tb_parallel_to_serial.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/parallel_to_serial.sv
// parallel_to_serial: accepts a width-bit word on a valid/ready handshake and
// emits it one bit per serial handshake, with serial_last on the final bit.
// A new word can load on the last-bit cycle, so back-to-back words stream
// with no idle cycle between them.
// Optional build macro: PARALLEL_TO_SERIAL_MSB_FIRST_EN selects MSB-first
// order (shift left). When it is undefined the order is LSB first (shift right).
module parallel_to_serial #(
   parameter int width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             parallel_valid,
   input  logic [width-1:0] parallel_data,
   output logic             parallel_ready,
   output logic             serial_valid,
   output logic             serial_data,
   output logic             serial_last,
   input  logic             serial_ready
);

   localparam int CW = $clog2(width);
   localparam logic [CW-1:0] LAST_CNT = CW'(width - 1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   logic [0:0]       state;
   logic [width-1:0] shreg;
   logic [CW-1:0]    cnt;
   logic             word_hs;
   logic             bit_hs;
   logic             out_bit;

`ifdef PARALLEL_TO_SERIAL_MSB_FIRST_EN
   assign out_bit = shreg[width-1];
`else
   assign out_bit = shreg[0];
`endif

   // Output and handshake decode. parallel_ready never looks at parallel_valid.
   always_comb begin
      serial_valid   = (state == ST_SHIFT);
      serial_last    = (state == ST_SHIFT) && (cnt == LAST_CNT);
      // Gate data so the line stays quiet while nothing is being sent.
      serial_data    = serial_valid && out_bit;
      parallel_ready = (state == ST_IDLE) || (serial_last && serial_ready);
      word_hs        = parallel_valid && parallel_ready;
      bit_hs         = serial_valid && serial_ready;
   end

   // FSM, shift register and bit counter. Back-pressure holds everything.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         shreg <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (word_hs) begin
                  shreg <= parallel_data;
                  cnt   <= '0;
                  state <= ST_SHIFT;
               end
            end
            default: begin
               if (bit_hs) begin
                  if (cnt != LAST_CNT) begin
`ifdef PARALLEL_TO_SERIAL_MSB_FIRST_EN
                     shreg <= {shreg[width-2:0], 1'b0};
`else
                     shreg <= {1'b0, shreg[width-1:1]};
`endif
                     cnt   <= cnt + CW'(1);
                  end else if (word_hs) begin
                     // Reload on the last bit: the new word's first bit
                     // follows with no bubble.
                     shreg <= parallel_data;
                     cnt   <= '0;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Bench for parallel_to_serial: directed scenarios followed by random traffic.
// A queue-based reference model checks every cycle. Each accepted word
// pushes its bits in transmit order. Each serial handshake pops one bit.
// When a word has been fully sent, the bits are reassembled and compared
// against the word that was accepted.
module tb_parallel_to_serial;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         parallel_valid;
   logic [W-1:0] parallel_data;
   logic         parallel_ready;
   logic         serial_valid;
   logic         serial_data;
   logic         serial_last;
   logic         serial_ready;

   int passed = 0;
   int total  = 0;

   bit           q[$];
   bit           rxbits[$];
   logic [W-1:0] words[$];
   bit           last_whs;

   parallel_to_serial #(.width(W)) dut (
      .clk(clk), .rst(rst),
      .parallel_valid(parallel_valid), .parallel_data(parallel_data),
      .parallel_ready(parallel_ready),
      .serial_valid(serial_valid), .serial_data(serial_data),
      .serial_last(serial_last), .serial_ready(serial_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle. Outputs are checked at the negedge. The model advances
   // at the posedge, and control returns 1ns after that edge.
   task automatic tick();
      bit whs, bhs, mready;
      logic [W-1:0] rx;
      logic [W-1:0] exp_word;
      @(negedge clk);
      mready = (q.size() == 0) || (q.size() == 1 && serial_ready);
      chk("serial_valid", 32'(serial_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         chk("serial_data", 32'(serial_data), 32'(q[0]));
         chk("serial_last", 32'(serial_last), 32'(q.size() == 1));
      end
      chk("parallel_ready", 32'(parallel_ready), 32'(mready));
      whs = parallel_valid && mready;
      bhs = (q.size() != 0) && serial_ready;
      @(posedge clk);
      if (bhs) begin
         rxbits.push_back(q.pop_front());
         if (q.size() == 0) begin
            rx = '0;
            for (int k = 0; k < W; k++) begin
`ifdef PARALLEL_TO_SERIAL_MSB_FIRST_EN
               rx[W-1-k] = rxbits[k];
`else
               rx[k] = rxbits[k];
`endif
            end
            rxbits.delete();
            exp_word = words.pop_front();
            chk("word", 32'(rx), 32'(exp_word));
         end
      end
      if (whs) begin
         words.push_back(parallel_data);
         for (int k = 0; k < W; k++) begin
`ifdef PARALLEL_TO_SERIAL_MSB_FIRST_EN
            q.push_back(parallel_data[W-1-k]);
`else
            q.push_back(parallel_data[k]);
`endif
         end
      end
      last_whs = whs;
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_serial_valid"}, 32'(serial_valid), 32'd0);
      chk({tag, "_serial_data"}, 32'(serial_data), 32'd0);
      chk({tag, "_serial_last"}, 32'(serial_last), 32'd0);
      chk({tag, "_parallel_ready"}, 32'(parallel_ready), 32'd1);
   endtask

   initial begin
      rst = 1'b0;
      parallel_valid = 1'b0;
      parallel_data = '0;
      serial_ready = 1'b1;

      // Hold reset while the inputs toggle randomly.
      for (int i = 0; i < 3; i++) begin
         parallel_valid = 1'($urandom);
         parallel_data  = W'($urandom);
         serial_ready   = 1'($urandom);
         #7;
         chk_reset_outputs("reset");
      end
      parallel_valid = 1'b0;
      serial_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      tick();

      // Single word 8'hA5 with serial_ready held high.
      parallel_valid = 1'b1; parallel_data = 8'hA5;
      tick();
      parallel_valid = 1'b0;
      repeat (9) tick();

      // 8'hFF then 8'h00 back to back, with parallel_valid held.
      parallel_valid = 1'b1; parallel_data = 8'hFF;
      tick();
      parallel_data = 8'h00;
      repeat (8) tick();
      parallel_valid = 1'b0;
      repeat (9) tick();

      // 8'h3C with serial_ready low for 3 cycles on bit 4.
      parallel_valid = 1'b1; parallel_data = 8'h3C;
      tick();
      parallel_valid = 1'b0;
      repeat (4) tick();
      serial_ready = 1'b0;
      repeat (3) tick();
      serial_ready = 1'b1;
      repeat (5) tick();

      // Stall on the last bit while the next word waits upstream.
      parallel_valid = 1'b1; parallel_data = 8'h5A;
      tick();
      parallel_data = 8'hC3;
      repeat (7) tick();
      serial_ready = 1'b0;
      repeat (3) tick();
      serial_ready = 1'b1;
      tick();
      parallel_valid = 1'b0;
      repeat (9) tick();

      // Reset in the middle of a word, then send 8'h81 cleanly.
      parallel_valid = 1'b1; parallel_data = 8'h96;
      tick();
      parallel_valid = 1'b0;
      repeat (3) tick();
      #2;
      rst = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      q.delete(); rxbits.delete(); words.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      parallel_valid = 1'b1; parallel_data = 8'h81;
      tick();
      parallel_valid = 1'b0;
      repeat (9) tick();

      // Random traffic. An offered word is held until it is accepted.
      for (int i = 0; i < 400; i++) begin
         if (!parallel_valid && ($urandom % 3 != 0)) begin
            parallel_valid = 1'b1;
            parallel_data  = W'($urandom);
         end
         serial_ready = ($urandom % 4 != 0);
         tick();
         if (last_whs) parallel_valid = 1'b0;
      end
      parallel_valid = 1'b0;
      serial_ready = 1'b1;
      repeat (W + 2) tick();
      chk("drained", 32'(words.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
